// File: rtl/shift_out_8b.sv
// shift_out_8b: parallel-in / serial-out transmitter for the CPU output port.
// A byte is captured on a load request and shifted out one bit per enable
// tick. The idle line level is high. busy and done tell the sequencer when
// it can issue the next byte.
// Optional build macro SHIFT_OUT_PARITY_EN appends an even-parity bit
// (XOR of the captured data) after the last data bit.
module shift_out_8b #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             input_clear,
  input  logic [WIDTH-1:0] input_d,
  input  logic             input_load,
  input  logic             input_clock_enable,
  output logic             output_serial,
  output logic             output_busy,
  output logic             output_done
);

`ifdef SHIFT_OUT_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t          state_q;
  logic [FW-1:0]   sr_q;
  logic [CW-1:0]   cnt_q;
  logic            serial_q;
  logic            busy_q;
  logic            done_q;

  logic [FW-1:0]   load_frame_d;
  logic [FW-1:0]   sr_shift_d;
  logic            load_first_d;
  logic            shift_first_d;

  // Build the frame to capture and the one-step-shifted register; the
  // output end is bit 0 (LSB first) or bit FW-1 (MSB first).
  always_comb begin
    load_frame_d  = '0;
    sr_shift_d    = '0;
`ifdef SHIFT_OUT_PARITY_EN
    // Parity sits at the far end of the register so it leaves last.
    if (MSB_FIRST) load_frame_d = {input_d, ^input_d};
    else           load_frame_d = {^input_d, input_d};
`else
    load_frame_d = input_d;
`endif
    if (MSB_FIRST) sr_shift_d = {sr_q[FW-2:0], 1'b0};
    else           sr_shift_d = {1'b0, sr_q[FW-1:1]};
    load_first_d  = MSB_FIRST ? load_frame_d[FW-1] : load_frame_d[0];
    shift_first_d = MSB_FIRST ? sr_shift_d[FW-1]   : sr_shift_d[0];
  end

  // Frame sequencer with registered serial/busy/done outputs.
  always_ff @(posedge clock) begin
    if (input_clear) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (input_load) begin
            state_q  <= ST_SHIFT;
            sr_q     <= load_frame_d;
            cnt_q    <= '0;
            serial_q <= load_first_d;
            busy_q   <= 1'b1;
          end else begin
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (input_clock_enable) begin
            if (cnt_q == LAST) begin
              state_q  <= ST_DONE;
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              cnt_q    <= cnt_q + CW'(1);
              sr_q     <= sr_shift_d;
              serial_q <= shift_first_d;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (input_load) begin
            state_q  <= ST_SHIFT;
            sr_q     <= load_frame_d;
            cnt_q    <= '0;
            serial_q <= load_first_d;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign output_serial = serial_q;
  assign output_busy   = busy_q;
  assign output_done   = done_q;

endmodule

// File: tb/tb_shift_out_8b.sv
// tb_shift_out_8b: directed bench for shift_out_8b. Two instances share all
// inputs, one LSB-first and one MSB-first, so every frame checks both orders.
// Honours SHIFT_OUT_PARITY_EN by expecting the extra parity bit period.
module tb_shift_out_8b;

`ifdef SHIFT_OUT_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clock = 1'b0;
  logic       input_clear = 1'b1;
  logic [7:0] input_d = 8'h00;
  logic       input_load = 1'b0;
  logic       input_clock_enable = 1'b0;
  logic       ser_l, busy_l, done_l;
  logic       ser_m, busy_m, done_m;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  shift_out_8b #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .input_clear(input_clear), .input_d(input_d),
    .input_load(input_load), .input_clock_enable(input_clock_enable),
    .output_serial(ser_l), .output_busy(busy_l), .output_done(done_l)
  );

  shift_out_8b #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clock(clock), .input_clear(input_clear), .input_d(input_d),
    .input_load(input_load), .input_clock_enable(input_clock_enable),
    .output_serial(ser_m), .output_busy(busy_m), .output_done(done_m)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one edge; checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected line level for bit period k of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int k, input bit msb);
    if (k >= 8) return ^d;
    return msb ? d[7-k] : d[k];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " ser_l"}, ser_l, 1'b1);
    chk({tag, " busy_l"}, busy_l, 1'b0);
    chk({tag, " done_l"}, done_l, 1'b0);
    chk({tag, " ser_m"}, ser_m, 1'b1);
    chk({tag, " busy_m"}, busy_m, 1'b0);
    chk({tag, " done_m"}, done_m, 1'b0);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, " done ser_l"}, ser_l, 1'b1);
    chk({tag, " done busy_l"}, busy_l, 1'b0);
    chk({tag, " done done_l"}, done_l, 1'b1);
    chk({tag, " done ser_m"}, ser_m, 1'b1);
    chk({tag, " done busy_m"}, busy_m, 1'b0);
    chk({tag, " done done_m"}, done_m, 1'b1);
  endtask

  // Load with enable high at the load edge; data is then scrambled to prove
  // it is only sampled on acceptance.
  task automatic do_load(input logic [7:0] d);
    input_d = d;
    input_load = 1'b1;
    input_clock_enable = 1'b1;
    tick();
    input_load = 1'b0;
    input_d = ~d;
  endtask

  // Walk every bit period; enable pulses on the last cycle of each period.
  // With spurious set, a load of 8'hF0 is requested mid-frame.
  task automatic run_bits(input string tag, input logic [7:0] d, input int period,
                          input bit spurious);
    for (int k = 0; k < NB; k++) begin
      if (spurious && k == 2) begin input_load = 1'b1; input_d = 8'hF0; end
      if (spurious && k == 4) begin input_load = 1'b0; input_d = 8'h00; end
      for (int c = 0; c < period; c++) begin
        input_clock_enable = (c == period - 1);
        chk($sformatf("%s bit%0d ser_l", tag, k), ser_l, exp_bit(d, k, 1'b0));
        chk($sformatf("%s bit%0d ser_m", tag, k), ser_m, exp_bit(d, k, 1'b1));
        chk($sformatf("%s bit%0d busy", tag, k), busy_l & busy_m, 1'b1);
        chk($sformatf("%s bit%0d done", tag, k), done_l | done_m, 1'b0);
        tick();
      end
    end
    input_clock_enable = 1'b0;
  endtask

  initial begin
    // 1. Reset held with load and data active.
    input_load = 1'b1;
    input_d = 8'hFF;
    input_clock_enable = 1'b1;
    tick();
    chk_idle("rst c1");
    tick();
    chk_idle("rst c2");
    input_clear = 1'b0;
    input_load = 1'b0;
    tick();
    chk_idle("rst rel");

    // 2. Basic frame A5: LSB order 1,0,1,0,0,1,0,1.
    do_load(8'hA5);
    chk("A5 c1 ser_l", ser_l, 1'b1);
    chk("A5 c1 ser_m", ser_m, 1'b1);
    run_bits("A5", 8'hA5, 1, 1'b0);
    chk_done("A5");
    tick();
    chk_idle("A5 after");

    // 3. Slow tick, every 4th cycle.
    do_load(8'h3C);
    chk("3C c1 ser_m", ser_m, 1'b0);
    run_bits("3C", 8'h3C, 4, 1'b0);
    chk_done("3C");
    tick();
    chk_idle("3C after");

    // 4. Load ignored during SHIFT, accepted in DONE.
    do_load(8'h0F);
    run_bits("0F", 8'h0F, 1, 1'b1);
    chk_done("0F");
    input_d = 8'hF0;
    input_load = 1'b1;
    tick();
    input_load = 1'b0;
    chk("b2b F0 first ser_l", ser_l, 1'b0);
    chk("b2b F0 first ser_m", ser_m, 1'b1);
    run_bits("F0", 8'hF0, 1, 1'b0);
    chk_done("F0");
    tick();
    chk_idle("F0 after");

    // 5. Clear in cycle 4 of an FF frame aborts without done.
    do_load(8'hFF);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("FF c%0d ser_l", c), ser_l, 1'b1);
      chk($sformatf("FF c%0d busy", c), busy_l, 1'b1);
      tick();
    end
    chk("FF c4 busy", busy_l, 1'b1);
    input_clear = 1'b1;
    tick();
    input_clear = 1'b0;
    chk_idle("abort");
    for (int c = 0; c < 10; c++) begin
      input_clock_enable = 1'b1;
      tick();
      chk_idle($sformatf("abort quiet%0d", c));
    end
    do_load(8'h55);
    run_bits("55", 8'h55, 1, 1'b0);
    chk_done("55");
    tick();
    chk_idle("55 after");

    // 6. Parity-sensitive frames (parity 1 for 07, 0 for 03).
    do_load(8'h07);
    run_bits("07", 8'h07, 1, 1'b0);
    chk_done("07");
    tick();
    do_load(8'h03);
    run_bits("03", 8'h03, 1, 1'b0);
    chk_done("03");
    tick();
    chk_idle("03 after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
